// File: rtl/pci_target_if.sv
// pci_target_if: target-side bus pins of one device slot, split into in/out/oe
interface pci_target_if;
  logic        frame_n;
  logic        irdy_n;
  logic        cmd;
  logic [31:0] addr_data_in;
  logic [31:0] addr_data_out;
  logic        addr_data_oe;
  logic        trdy_n;
  logic        devsel_n;
  logic        tgt_oe;
  logic        busy;
  logic        xfer_done;
  modport master (
    output frame_n, irdy_n, cmd, addr_data_in,
    input  addr_data_out, addr_data_oe, trdy_n, devsel_n, tgt_oe, busy, xfer_done
  );
  modport slave (
    input  frame_n, irdy_n, cmd, addr_data_in,
    output addr_data_out, addr_data_oe, trdy_n, devsel_n, tgt_oe, busy, xfer_done
  );
endinterface

// File: rtl/pci_target_responder.sv
// pci_target_responder: claims matching frames and serves burst reads/writes from local memory
module pci_target_responder #(
  parameter logic DEV_SEL_VAL = 1'b0,
  parameter int   MEM_DEPTH   = 16,
  parameter int   WAIT_STATES = 0
) (
  input logic         clk,
  input logic         rst_n,
  pci_target_if.slave bus
);
  localparam int AW = $clog2(MEM_DEPTH);
  typedef enum logic [1:0] {IDLE, TURN, DATA, RELEASE} state_t;
  state_t         state;
  logic           frame_q;
  logic           cmd_r;
  logic [AW-1:0]  idx;
  logic [AW-1:0]  idx_nx;
  logic [2:0]     wait_cnt;
  logic           xfer;
  logic [31:0]    mem [MEM_DEPTH];
  assign xfer   = state == DATA && !bus.irdy_n && !bus.trdy_n;
  assign idx_nx = (idx == AW'(MEM_DEPTH - 1)) ? '0 : idx + 1'b1;
  // bus FSM: decode, turnaround, data phases with optional wait states, release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      frame_q           <= 1'b1;
      cmd_r             <= 1'b0;
      idx               <= '0;
      wait_cnt          <= '0;
      bus.trdy_n        <= 1'b1;
      bus.devsel_n      <= 1'b1;
      bus.tgt_oe        <= 1'b0;
      bus.addr_data_oe  <= 1'b0;
      bus.addr_data_out <= '0;
      bus.busy          <= 1'b0;
      bus.xfer_done     <= 1'b0;
    end else begin
      frame_q <= bus.frame_n;
      case (state)
        IDLE: if (!bus.frame_n && frame_q) begin
          idx   <= bus.addr_data_in[AW-1:0];
          cmd_r <= bus.cmd;
          if (bus.addr_data_in[4] == DEV_SEL_VAL) begin
            state    <= TURN;
            bus.busy <= 1'b1;
          end
        end
        TURN: begin
          state        <= DATA;
          bus.tgt_oe   <= 1'b1;
          bus.devsel_n <= 1'b0;
          bus.trdy_n   <= WAIT_STATES != 0;
          wait_cnt     <= 3'(WAIT_STATES);
          if (cmd_r) begin
            bus.addr_data_out <= mem[idx];
            bus.addr_data_oe  <= 1'b1;
          end
        end
        DATA: begin
          if (wait_cnt != 3'd0) begin
            wait_cnt   <= wait_cnt - 1'b1;
            bus.trdy_n <= wait_cnt != 3'd1;
          end
          if (xfer) begin
            idx <= idx_nx;
            if (cmd_r) bus.addr_data_out <= mem[idx_nx];
          end
          if (bus.frame_n && (xfer || bus.irdy_n)) begin
            state            <= RELEASE;
            bus.trdy_n       <= 1'b1;
            bus.devsel_n     <= 1'b1;
            bus.addr_data_oe <= 1'b0;
            bus.xfer_done    <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          bus.tgt_oe    <= 1'b0;
          bus.xfer_done <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end
  // local word memory, deliberately not reset so data survives a bus reset
  always_ff @(posedge clk) begin
    if (xfer && !cmd_r) mem[idx] <= bus.addr_data_in;
  end
endmodule

// File: tb/tb_pci_target_responder.sv
// tb_pci_target_responder: directed bursts against a no-wait and a two-wait-state target
module tb_pci_target_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        frame_n = 1'b1;
  logic        irdy_n = 1'b1;
  logic        cmd = 1'b0;
  logic [31:0] ad = '0;
  always #5 clk = ~clk;
  pci_target_if b0();
  pci_target_if b1();
  assign b0.frame_n = sel | frame_n;
  assign b1.frame_n = !sel | frame_n;
  assign b0.irdy_n = irdy_n;
  assign b1.irdy_n = irdy_n;
  assign b0.cmd = cmd;
  assign b1.cmd = cmd;
  assign b0.addr_data_in = ad;
  assign b1.addr_data_in = ad;
  pci_target_responder #(.DEV_SEL_VAL(1'b1), .MEM_DEPTH(16), .WAIT_STATES(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
  pci_target_responder #(.DEV_SEL_VAL(1'b1), .MEM_DEPTH(16), .WAIT_STATES(2)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  logic [31:0] dout;
  logic        doe, trdy, devsel, toe, busy, xd;
  assign dout   = sel ? b1.addr_data_out : b0.addr_data_out;
  assign doe    = sel ? b1.addr_data_oe : b0.addr_data_oe;
  assign trdy   = sel ? b1.trdy_n : b0.trdy_n;
  assign devsel = sel ? b1.devsel_n : b0.devsel_n;
  assign toe    = sel ? b1.tgt_oe : b0.tgt_oe;
  assign busy   = sel ? b1.busy : b0.busy;
  assign xd     = sel ? b1.xfer_done : b0.xfer_done;
  localparam logic [31:0] WA = 32'hA0A0_0001, WB = 32'hB0B0_0002, WC = 32'hC0C0_0003;
  localparam logic [31:0] WX = 32'h1111_2222, WY = 32'h3333_4444, WP = 32'h5A5A_5A5A, WQ = 32'h6B6B_6B6B;
  int checks = 0;
  int failures = 0;
  logic [31:0] wd [8];
  logic [31:0] rd [8];
  int tcount, xd_cnt, wait_cyc, dev_lat, trdy_lat;
  logic oe_seen, toe_seen, busy_seen, oe_first, busy_last, busy_rel;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic clr;
    tcount = 0; xd_cnt = 0; wait_cyc = 0; dev_lat = 0; trdy_lat = 0;
    oe_seen = 0; toe_seen = 0; busy_seen = 0; oe_first = 0;
  endtask
  task automatic mon;
    tcount++;
    xd_cnt += int'(xd);
    oe_seen |= doe;
    toe_seen |= toe;
    busy_seen |= busy;
    if (!devsel && dev_lat == 0) begin
      dev_lat = tcount;
      oe_first = doe;
    end
    if (!trdy && trdy_lat == 0) trdy_lat = tcount;
    if (!devsel && trdy) wait_cyc++;
  endtask
  task automatic burst(input logic rd_cmd, input logic [31:0] addr, input int n, input int stall_at);
    logic pt;
    logic [31:0] pdat;
    int guard;
    clr();
    frame_n = 1'b0; cmd = rd_cmd; ad = addr; irdy_n = 1'b1;
    tick(); mon();
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        irdy_n = 1'b1;
        repeat (2) begin
          tick(); mon();
          chk("stall_data", dout, wd[i]);
        end
      end
      ad = wd[i]; irdy_n = 1'b0; frame_n = (i == n - 1);
      guard = 0;
      do begin
        pt = trdy; pdat = dout;
        tick(); mon();
        guard++;
      end while (pt !== 1'b0 && guard < 12);
      chk("xfer_seen", 32'(pt), 32'd0);
      rd[i] = pdat;
    end
    frame_n = 1'b1; irdy_n = 1'b1;
    busy_last = busy;
    tick(); mon();
    busy_rel = busy;
    repeat (2) begin tick(); mon(); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_trdy", 32'(trdy), 32'd1);
    chk("rst_devsel", 32'(devsel), 32'd1);
    chk("rst_tgt_oe", 32'(toe), 32'd0);
    chk("rst_ad_oe", 32'(doe), 32'd0);
    chk("rst_ad_out", dout, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_xfer_done", 32'(xd), 32'd0);
    rst_n = 1'b1;
    tick();
    wd[0] = WA; wd[1] = WB; wd[2] = WC;
    burst(1'b0, 32'h0000_0012, 3, -1);
    chk("t1_devsel_lat", dev_lat, 2);
    chk("t1_trdy_lat", trdy_lat, 2);
    chk("t1_xfer_done_cnt", xd_cnt, 1);
    chk("t1_tgt_oe_seen", 32'(toe_seen), 32'd1);
    chk("t1_ad_oe_seen", 32'(oe_seen), 32'd0);
    burst(1'b1, 32'h0000_0012, 3, -1);
    chk("t2_rd0", rd[0], WA);
    chk("t2_rd1", rd[1], WB);
    chk("t2_rd2", rd[2], WC);
    chk("t2_oe_at_data", 32'(oe_first), 32'd1);
    chk("t2_oe_after", 32'(doe), 32'd0);
    chk("t2_xfer_done_cnt", xd_cnt, 1);
    clr();
    frame_n = 1'b0; cmd = 1'b0; ad = 32'h0000_0002;
    tick(); mon();
    ad = 32'hDEAD_BEEF; irdy_n = 1'b0;
    repeat (4) begin tick(); mon(); end
    frame_n = 1'b1;
    tick(); mon();
    irdy_n = 1'b1;
    repeat (2) begin tick(); mon(); end
    chk("t3_tgt_oe", 32'(toe_seen), 32'd0);
    chk("t3_ad_oe", 32'(oe_seen), 32'd0);
    chk("t3_busy", 32'(busy_seen), 32'd0);
    wd[0] = WX; wd[1] = WY;
    burst(1'b0, 32'h0000_001F, 2, -1);
    chk("t4_busy_last", 32'(busy_last), 32'd1);
    chk("t4_busy_rel", 32'(busy_rel), 32'd0);
    burst(1'b1, 32'h0000_001F, 2, -1);
    chk("t4_mem15", rd[0], WX);
    chk("t4_mem0", rd[1], WY);
    wd[0] = WA; wd[1] = WB; wd[2] = WC;
    burst(1'b1, 32'h0000_0012, 3, -1);
    chk("t3_mem2", rd[0], WA);
    chk("t3_mem3", rd[1], WB);
    chk("t3_mem4", rd[2], WC);
    sel = 1'b1;
    for (int i = 0; i < 4; i++) wd[i] = 32'hD000_0000 + 32'(i * 17 + 3);
    burst(1'b0, 32'h0000_0013, 4, -1);
    chk("t5_w_trdy_lat", trdy_lat, 4);
    chk("t5_w_wait_cyc", wait_cyc, 2);
    burst(1'b1, 32'h0000_0013, 4, 2);
    chk("t5_wait_cyc", wait_cyc, 2);
    for (int i = 0; i < 4; i++) chk("t5_rd", rd[i], wd[i]);
    sel = 1'b0;
    frame_n = 1'b0; cmd = 1'b0; ad = 32'h0000_0015; irdy_n = 1'b1;
    tick();
    ad = WP; irdy_n = 1'b0;
    tick();
    tick();
    ad = WQ;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_trdy", 32'(trdy), 32'd1);
    chk("t6_devsel", 32'(devsel), 32'd1);
    chk("t6_tgt_oe", 32'(toe), 32'd0);
    chk("t6_ad_oe", 32'(doe), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    frame_n = 1'b1; irdy_n = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    wd[0] = 32'h0;
    burst(1'b1, 32'h0000_0015, 1, -1);
    chk("t6_first_word", rd[0], WP);
    chk("t6_devsel_lat", dev_lat, 2);
    chk("t6_xfer_done_cnt", xd_cnt, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
